// File: rtl/mem_bus_arbiter_if.sv
// Pipelined Wishbone master port shared by the
// instruction and data masters of mem_bus_arbiter.
interface mem_bus_arbiter_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_wr_en;
    logic [31:0] wb_addr;
    logic [31:0] wb_wr_data;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_stall;
    logic [31:0] wb_rd_data;

    modport master (
        output wb_cyc,
        output wb_stb,
        output wb_wr_en,
        output wb_addr,
        output wb_wr_data,
        output wb_sel,
        input  wb_ack,
        input  wb_stall,
        input  wb_rd_data
    );

    modport slave (
        input  wb_cyc,
        input  wb_stb,
        input  wb_wr_en,
        input  wb_addr,
        input  wb_wr_data,
        input  wb_sel,
        output wb_ack,
        output wb_stall,
        output wb_rd_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter of fetch and data masters onto one
// pipelined Wishbone port, single outstanding transaction.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_stb,
    input  logic [31:0]       ins_addr,
    output logic              ins_ack,
    output logic              ins_err,
    output logic [31:0]       ins_rd_data,
    input  logic              dat_stb,
    input  logic              dat_wr_en,
    input  logic [31:0]       dat_addr,
    input  logic [31:0]       dat_wr_data,
    input  logic [3:0]        dat_sel,
    output logic              dat_ack,
    output logic              dat_err,
    output logic [31:0]       dat_rd_data,
    mem_bus_arbiter_if.master wb,
    output logic              grant,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE, REQ, WAIT, DONE
    } state_e;

    localparam logic [15:0] CNT_LAST =
        16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        iack_q, iack_d;
    logic        ierr_q, ierr_d;
    logic [31:0] ird_q, ird_d;
    logic        dack_q, dack_d;
    logic        derr_q, derr_d;
    logic [31:0] drd_q, drd_d;
    logic        pick;
    logic        done_en;
    logic        done_err;
    logic [31:0] done_rd;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        pick     = 1'b0;
        done_en  = 1'b0;
        done_err = 1'b0;
        done_rd  = '0;
        unique case (state_q)
            IDLE: begin
                if (ins_stb || dat_stb) begin
                    // dat wins alone, or on a tie after ins
                    pick    = dat_stb & (~ins_stb | ~last_q);
                    grant_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    state_d = REQ;
                    if (pick) begin
                        we_d   = dat_wr_en;
                        addr_d = dat_addr;
                        wdat_d = dat_wr_data;
                        sel_d  = dat_sel;
                    end else begin
                        we_d   = 1'b0;
                        addr_d = ins_addr;
                        wdat_d = '0;
                        sel_d  = 4'hF;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (!wb.wb_stall && wb.wb_ack) begin
                    done_en = 1'b1;
                    done_rd = wb.wb_rd_data;
                end else if (cnt_q == CNT_LAST) begin
                    done_en  = 1'b1;
                    done_err = 1'b1;
                end else if (!wb.wb_stall) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (wb.wb_ack) begin
                    done_en = 1'b1;
                    done_rd = wb.wb_rd_data;
                end else if (cnt_q == CNT_LAST) begin
                    done_en  = 1'b1;
                    done_err = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        if (done_en) begin
            state_d = DONE;
        end
        cyc_d  = (state_d == REQ) || (state_d == WAIT);
        stb_d  = (state_d == REQ);
        iack_d = done_en & ~grant_q;
        ierr_d = done_en & done_err & ~grant_q;
        ird_d  = iack_d ? done_rd : '0;
        dack_d = done_en & grant_q;
        derr_d = done_en & done_err & grant_q;
        drd_d  = dack_d ? done_rd : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            iack_q  <= 1'b0;
            ierr_q  <= 1'b0;
            ird_q   <= '0;
            dack_q  <= 1'b0;
            derr_q  <= 1'b0;
            drd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            iack_q  <= iack_d;
            ierr_q  <= ierr_d;
            ird_q   <= ird_d;
            dack_q  <= dack_d;
            derr_q  <= derr_d;
            drd_q   <= drd_d;
        end
    end

    assign wb.wb_cyc     = cyc_q;
    assign wb.wb_stb     = stb_q;
    assign wb.wb_wr_en   = we_q;
    assign wb.wb_addr    = addr_q;
    assign wb.wb_wr_data = wdat_q;
    assign wb.wb_sel     = sel_q;
    assign ins_ack       = iack_q;
    assign ins_err       = ierr_q;
    assign ins_rd_data   = ird_q;
    assign dat_ack       = dack_q;
    assign dat_err       = derr_q;
    assign dat_rd_data   = drd_q;
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random masters,
// memory-like slave model, decoupled response monitor.
module tb_mem_bus_arbiter;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ins_stb;
    logic [31:0] ins_addr;
    logic        ins_ack;
    logic        ins_err;
    logic [31:0] ins_rd_data;
    logic        dat_stb;
    logic        dat_wr_en;
    logic [31:0] dat_addr;
    logic [31:0] dat_wr_data;
    logic [3:0]  dat_sel;
    logic        dat_ack;
    logic        dat_err;
    logic [31:0] dat_rd_data;
    logic        grant;
    logic        busy;

    mem_bus_arbiter_if wb();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ins_stb     (ins_stb),
        .ins_addr    (ins_addr),
        .ins_ack     (ins_ack),
        .ins_err     (ins_err),
        .ins_rd_data (ins_rd_data),
        .dat_stb     (dat_stb),
        .dat_wr_en   (dat_wr_en),
        .dat_addr    (dat_addr),
        .dat_wr_data (dat_wr_data),
        .dat_sel     (dat_sel),
        .dat_ack     (dat_ack),
        .dat_err     (dat_err),
        .dat_rd_data (dat_rd_data),
        .wb          (wb),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic        we;
    } bus_t;

    rsp_t rsp_i[$];
    rsp_t rsp_d[$];
    bus_t bus_i[$];
    bus_t bus_d[$];
    logic glog[$];

    int total = 0;
    int bad   = 0;

    bit          s_rand;
    int          s_stall;
    int          s_lat;
    bit          s_drop;
    logic [31:0] s_data;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // slave: memory-like responder with stall/latency/drop
    initial begin : slave
        bus_t cur;
        bus_t e;
        logic own;
        int   n;
        int   l;
        bit   drop;
        wb.wb_ack     = 1'b0;
        wb.wb_stall   = 1'b0;
        wb.wb_rd_data = '0;
        forever begin
            @(negedge clk);
            if (wb.wb_stb === 1'b1) begin
                own = grant;
                cur = '{wb.wb_addr, wb.wb_wr_data,
                        wb.wb_sel, wb.wb_wr_en};
                e = '0;
                if (own) begin
                    chk("bus_pop_d", 32'(bus_d.size() != 0), 1);
                    if (bus_d.size() != 0) e = bus_d.pop_front();
                end else begin
                    chk("bus_pop_i", 32'(bus_i.size() != 0), 1);
                    if (bus_i.size() != 0) e = bus_i.pop_front();
                end
                chk("bus_addr", cur.addr, e.addr);
                chk("bus_wd", cur.wd, e.wd);
                chk("bus_sel_we", {cur.sel, cur.we}, {e.sel, e.we});
                if (s_rand) begin
                    n    = $urandom_range(0, 3);
                    l    = $urandom_range(0, 3);
                    drop = cur.addr[31];
                end else begin
                    n    = s_stall;
                    l    = s_lat;
                    drop = s_drop;
                end
                for (int i = 0; i < n; i++) begin
                    wb.wb_stall = 1'b1;
                    @(negedge clk);
                    chk("stall_cs", {wb.wb_cyc, wb.wb_stb}, 2'b11);
                    chk("stall_addr", wb.wb_addr, cur.addr);
                    chk("stall_wd", wb.wb_wr_data, cur.wd);
                    chk("stall_sel", {wb.wb_sel, wb.wb_wr_en},
                        {cur.sel, cur.we});
                end
                wb.wb_stall = 1'b0;
                if (drop) begin
                    for (int i = 0; i < 4 * T && wb.wb_cyc === 1'b1; i++)
                        @(negedge clk);
                end else begin
                    for (int i = 0; i < l; i++) @(negedge clk);
                    wb.wb_ack     = 1'b1;
                    wb.wb_rd_data = s_rand ? f(cur.addr) : s_data;
                    @(negedge clk);
                    wb.wb_ack     = 1'b0;
                    wb.wb_rd_data = '0;
                end
            end
        end
    end

    initial begin : mon
        rsp_t r;
        forever begin
            @(negedge clk);
            if (ins_ack === 1'b1 || dat_ack === 1'b1)
                chk("one_ack", 32'(ins_ack & dat_ack), 0);
            if (ins_ack === 1'b1) begin
                chk("ins_pop", 32'(rsp_i.size() != 0), 1);
                if (rsp_i.size() != 0) begin
                    r = rsp_i.pop_front();
                    chk("ins_err", 32'(ins_err), 32'(r.err));
                    if (r.chk_rd) chk("ins_rd", ins_rd_data, r.rd);
                end
            end
            if (dat_ack === 1'b1) begin
                chk("dat_pop", 32'(rsp_d.size() != 0), 1);
                if (rsp_d.size() != 0) begin
                    r = rsp_d.pop_front();
                    chk("dat_err", 32'(dat_err), 32'(r.err));
                    if (r.chk_rd) chk("dat_rd", dat_rd_data, r.rd);
                end
            end
        end
    end

    // round-robin reference: tie goes to the one not granted last
    initial begin : arb
        bit   last;
        logic is;
        logic ds;
        logic exp;
        last = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                last = 1'b1;
            end else if (!busy && (ins_stb || dat_stb)) begin
                is  = ins_stb;
                ds  = dat_stb;
                exp = (is && ds) ? ~last : ds;
                @(posedge clk);
                #1;
                if (rst_n) begin
                    chk("grant", 32'(grant), 32'(exp));
                    chk("req_lat", {busy, wb.wb_cyc, wb.wb_stb}, 3'b111);
                    last = exp;
                    glog.push_back(exp);
                end
            end
        end
    end

    task automatic ins_txn(input logic [31:0] a,
                           input logic [31:0] rd,
                           input bit err, input bit mid);
        bit got;
        bus_i.push_back('{a, 32'h0, 4'hF, 1'b0});
        rsp_i.push_back('{err, 1'b1, err ? 32'h0 : rd});
        ins_addr = a;
        ins_stb  = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (ins_ack === 1'b1) got = 1;
            else if (mid && busy && !grant && wb.wb_cyc) ins_stb = 1'b0;
        end
        ins_stb = 1'b0;
        chk("ins_done", 32'(got), 1);
    endtask

    task automatic dat_txn(input logic [31:0] a,
                           input logic [31:0] wd,
                           input logic [3:0] sel,
                           input bit we,
                           input logic [31:0] rd,
                           input bit err, input bit mid);
        bit got;
        bus_d.push_back('{a, wd, sel, we});
        rsp_d.push_back('{err, err | ~we, err ? 32'h0 : rd});
        dat_addr    = a;
        dat_wr_data = wd;
        dat_sel     = sel;
        dat_wr_en   = we;
        dat_stb     = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (dat_ack === 1'b1) got = 1;
            else if (mid && busy && grant && wb.wb_cyc) dat_stb = 1'b0;
        end
        dat_stb = 1'b0;
        chk("dat_done", 32'(got), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {ins_ack, ins_err, dat_ack, dat_err,
            grant, busy, wb.wb_cyc, wb.wb_stb, wb.wb_wr_en}, 0);
        chk({nm, "_rd"}, ins_rd_data | dat_rd_data, 0);
        chk({nm, "_bus"}, wb.wb_addr | wb.wb_wr_data, 0);
        chk({nm, "_sel"}, 32'(wb.wb_sel), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : main
        int bc;
        int sc;
        int k;
        int acks;
        logic [31:0] a;
        ins_stb = 0; ins_addr = 0;
        dat_stb = 0; dat_wr_en = 0; dat_addr = 0;
        dat_wr_data = 0; dat_sel = 0;
        s_rand = 0; s_stall = 0; s_lat = 1;
        s_drop = 0; s_data = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1;
        @(negedge clk);

        // single fetch, ack in second wait cycle
        s_lat = 2; s_data = 32'h0000_0013;
        bc = 0; sc = 0;
        fork
            ins_txn(32'h10, 32'h13, 0, 0);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                bc += int'(busy);
                sc += int'(wb.wb_stb);
            end
        join
        chk("fetch_busy", bc, 4);
        chk("fetch_stb", sc, 1);
        @(negedge clk);

        // slave never acks
        s_drop = 1;
        k = 0;
        fork
            ins_txn(32'h20, 32'h0, 1, 0);
            begin
                @(posedge clk); #1;
                chk("to_req", 32'(wb.wb_stb), 1);
                while (k < 20) begin
                    @(posedge clk); #1;
                    k++;
                    if (ins_ack === 1'b1) break;
                end
                chk("to_lat", k, T);
                chk("to_flags", {ins_err, wb.wb_cyc}, 2'b10);
                chk("to_rd", ins_rd_data, 0);
            end
        join
        s_drop = 0;
        @(negedge clk);

        // stalled data write
        s_stall = 3; s_lat = 1; s_data = 32'h1234_5678;
        sc = 0;
        fork
            dat_txn(32'h40, 32'hDEAD_BEEF, 4'b0011, 1,
                    32'h0, 0, 0);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                sc += int'(wb.wb_stb);
            end
        join
        chk("stall_stb_cycles", sc, 4);
        s_stall = 0;
        @(negedge clk);

        // both masters held: strict alternation
        glog.delete();
        s_data = 32'hCAFE_0001;
        fork
            for (int i = 0; i < 4; i++)
                ins_txn(32'h100 + 32'(i * 4), s_data, 0, 0);
            for (int i = 0; i < 4; i++)
                dat_txn(32'h200 + 32'(i * 4), 32'h0, 4'hF, 0,
                        s_data, 0, 0);
        join
        chk("alt_n", glog.size(), 8);
        for (int i = 0; i < glog.size(); i++)
            chk("alt", 32'(glog[i]), 32'(i % 2));
        @(negedge clk);

        // reset while waiting; late ack must be ignored
        s_lat = 6;
        bus_i.push_back('{32'h80, 32'h0, 4'hF, 1'b0});
        ins_addr = 32'h80;
        ins_stb  = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst", {busy, wb.wb_cyc, wb.wb_stb}, 3'b110);
        #2 rst_n = 0;
        #1 chk_all_zero("arst");
        ins_stb = 0;
        @(negedge clk);
        #2 rst_n = 1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acks += int'(ins_ack | dat_ack);
        end
        chk("stray_ack", acks, 0);
        s_lat = 1; s_data = 32'h0000_0055;
        ins_txn(32'h84, 32'h55, 0, 0);

        // randomized traffic
        s_rand = 1;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a = $urandom;
                a[31] = ($urandom_range(0, 7) == 0);
                ins_txn(a, f(a), a[31], $urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < 40; i++) begin : dloop
                logic [31:0] da;
                bit we;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                da = $urandom;
                da[31] = ($urandom_range(0, 7) == 0);
                we = $urandom_range(0, 1) == 1;
                dat_txn(da, $urandom, 4'($urandom), we,
                        f(da), da[31], $urandom_range(0, 3) == 0);
            end
        join
        repeat (5) @(negedge clk);
        chk("rsp_left", rsp_i.size() + rsp_d.size(), 0);
        chk("bus_left", bus_i.size() + bus_d.size(), 0);
        chk("idle_end", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
